// File: rtl/datapath_tipo_r.sv
// -----------------------------------------------------------------------------
// datapath_tipo_r
// Single-cycle MIPS-style R-type datapath: 32x32 register file, ALU control
// decoder and 32-bit ALU. Each instruction reads rs/rt asynchronously, the ALU
// computes per funct, and the result is written to rd on the rising clock edge.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset; loads reg[i] = i
//   instruccion  R-type instruction word, stable across the sampling edge
//   ZF_DPTR      combinational ALU zero flag (1 when ALU result == 0)
//   dbg_addr     (DPTR_DBG_PORT_EN only) debug read address
//   dbg_data     (DPTR_DBG_PORT_EN only) asynchronous read of reg[dbg_addr]
//
// Build option: define DPTR_DBG_PORT_EN to add the third (debug) read port.
// -----------------------------------------------------------------------------
module datapath_tipo_r #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruccion,
   output logic             ZF_DPTR
`ifdef DPTR_DBG_PORT_EN
   ,
   input  logic [4:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
`endif
);

   typedef enum logic [2:0] {
      ALU_ZERO,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [5:0] funct;
   logic       unused_shamt;

   assign opcode       = instruccion[31:26];
   assign rs           = instruccion[25:21];
   assign rt           = instruccion[20:16];
   assign rd           = instruccion[15:11];
   assign funct        = instruccion[5:0];
   assign unused_shamt = ^instruccion[10:6];

   logic [WIDTH-1:0] regs_q [NREGS];

   alu_op_e          alu_op;
   logic             reg_write;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;

   // ALU control: anything that is not a supported R-type collapses to ALU_ZERO,
   // which both forces the result to 0 and suppresses the writeback.
   always_comb begin
      alu_op = ALU_ZERO;
      if (opcode == 6'h00) begin
         case (funct)
            6'h20:   alu_op = ALU_ADD;
            6'h22:   alu_op = ALU_SUB;
            6'h24:   alu_op = ALU_AND;
            6'h25:   alu_op = ALU_OR;
            6'h2A:   alu_op = ALU_SLT;
            default: alu_op = ALU_ZERO;
         endcase
      end
   end

   assign reg_write = (alu_op != ALU_ZERO) && (rd != 5'd0);

   // Register 0 is hard-wired to zero on every read port.
   assign op_a = (rs == 5'd0) ? '0 : regs_q[rs];
   assign op_b = (rt == 5'd0) ? '0 : regs_q[rt];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_res = '0;
      endcase
   end

   assign ZF_DPTR = (alu_res == '0);

   // No write bypass: reads see the old contents until the edge, so the
   // datapath has no combinational loop through the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= WIDTH'(i);
         end
      end else if (reg_write) begin
         regs_q[rd] <= alu_res;
      end
   end

`ifdef DPTR_DBG_PORT_EN
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_datapath_tipo_r.sv
module tb_datapath_tipo_r;

   logic        clk;
   logic        rst;
   logic [31:0] instruccion;
   logic        ZF_DPTR;
`ifdef DPTR_DBG_PORT_EN
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
`endif

   datapath_tipo_r #(.WIDTH(32), .NREGS(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruccion (instruccion),
      .ZF_DPTR     (ZF_DPTR)
`ifdef DPTR_DBG_PORT_EN
      ,
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        zf;
      logic [31:0] ins;
      string       nm;
   } sb_item_t;

   sb_item_t    sb_q[$];
   logic        vld;
   int          n_vec;
   int          n_fail;
   logic [31:0] m_regs [32];

   // Reference model: architectural register file plus the R-type rules.
   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
   endtask

   function automatic void model_exec(input logic [31:0] ins,
                                      output logic [31:0] res,
                                      output logic we);
      logic [31:0] a;
      logic [31:0] b;
      logic        ok;
      a   = (ins[25:21] == 5'd0) ? 32'd0 : m_regs[ins[25:21]];
      b   = (ins[20:16] == 5'd0) ? 32'd0 : m_regs[ins[20:16]];
      ok  = 1'b1;
      res = 32'd0;
      if (ins[31:26] != 6'd0) ok = 1'b0;
      else begin
         case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
         endcase
      end
      if (!ok) res = 32'd0;
      we = ok && (ins[15:11] != 5'd0);
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] f, input int rs_n,
                                         input int rt_n, input int rd_n);
      return {6'd0, 5'(rs_n), 5'(rt_n), 5'(rd_n), 5'd0, f};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  ftab [5];
      logic [31:0] ins;
      int          sel;
      ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24;
      ftab[3] = 6'h25; ftab[4] = 6'h2A;
      sel = int'($urandom_range(0, 9));
      ins = rtype(ftab[$urandom_range(0, 4)], int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      if (sel == 0) ins[31:26] = 6'($urandom_range(1, 63));
      if (sel == 1) ins[5:0]   = 6'($urandom_range(0, 63));
      ins[10:6] = 5'($urandom);
      return ins;
   endfunction

   // Driver: called at posedge+1. exp_zf < 0 means take the expectation from
   // the model; otherwise use the hand-derived constant.
   task automatic issue(input logic [31:0] ins, input int exp_zf, input string nm);
      logic [31:0] res;
      logic        we;
      sb_item_t    it;
      model_exec(ins, res, we);
      instruccion = ins;
      it.zf  = (exp_zf < 0) ? (res == 32'd0) : exp_zf[0];
      it.ins = ins;
      it.nm  = nm;
      sb_q.push_back(it);
      vld = 1'b1;
      @(posedge clk);
      if (!rst && we) m_regs[ins[15:11]] = res;
      #1;
   endtask

   // Monitor: compares the flag mid-cycle while the instruction is stable.
   always @(negedge clk) begin
      if (vld) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: ZF_DPTR=%b with no expected entry", ZF_DPTR);
         end else begin
            sb_item_t it;
            it = sb_q.pop_front();
            if (ZF_DPTR !== it.zf)
            begin
               n_fail++;
               $display("FAIL %s: ZF_DPTR=%b expected %b (instr=%08h)",
                        it.nm, ZF_DPTR, it.zf, it.ins);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
      $fatal(1);
   end

   initial begin
      n_vec       = 0;
      n_fail      = 0;
      vld         = 1'b0;
      rst         = 1'b1;
      instruccion = 32'd0;
`ifdef DPTR_DBG_PORT_EN
      dbg_addr    = 5'd0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      issue(32'h01E9A022,                 0, "sub_r20_r15_r9");
      issue(rtype(6'h22, 20, 6, 0),       1, "chk_r20_eq_6");
      issue(32'h00000000,                 1, "nop");
      issue(rtype(6'h22, 20, 6, 0),       1, "nop_no_write");
      issue(32'h0289A022,                 0, "sub_r20_r20_r9");
      issue(rtype(6'h20, 20, 3, 0),       1, "chk_r20_eq_m3");
      issue(32'h00AF7820,                 0, "add_r15_r5_r15");
      issue(rtype(6'h2A, 19, 15, 0),      0, "chk_r15_gt_19");
      issue(rtype(6'h2A, 15, 21, 0),      0, "chk_r15_lt_21");
      issue(32'h012F7820,                 0, "add_r15_r9_r15");
      issue(rtype(6'h22, 15, 29, 0),      1, "chk_r15_eq_29");
      issue(32'h028FA82A,                 0, "slt_r21_r20_r15");
      issue(rtype(6'h22, 21, 1, 0),       1, "chk_r21_eq_1");
      issue(rtype(6'h2A, 15, 20, 21),     1, "slt_r21_r15_r20");
      issue(rtype(6'h24, 21, 21, 0),      1, "chk_r21_eq_0");
      issue(rtype(6'h24, 3, 5, 22),       0, "and_r3_r5");
      issue(rtype(6'h22, 22, 1, 0),       1, "chk_and_eq_1");
      issue(rtype(6'h25, 3, 5, 23),       0, "or_r3_r5");
      issue(rtype(6'h22, 23, 7, 0),       1, "chk_or_eq_7");
      issue(rtype(6'h22, 5, 5, 5),        1, "sub_r5_r5_r5");
      issue(rtype(6'h25, 5, 0, 0),        1, "chk_r5_eq_0");
      issue(rtype(6'h20, 31, 31, 0),      0, "add_r0_r31_r31");
      issue(rtype(6'h25, 0, 0, 0),        1, "chk_r0_eq_0");
      issue({6'd8, 5'd3, 5'd5, 5'd24, 5'd0, 6'h20}, 1, "opcode_nonzero");
      issue(rtype(6'h24, 24, 24, 0),      0, "chk_r24_kept");
      issue(rtype(6'h21, 3, 5, 25),       1, "funct_unsupported");
      issue(rtype(6'h24, 25, 25, 0),      0, "chk_r25_kept");

      // Asynchronous reset between edges: r20 (-3) must revert to 20 at once.
      rst = 1'b1;
      model_reset();
      issue(rtype(6'h2A, 20, 19, 0),      1, "rst_r20_not_lt_19");
      issue(rtype(6'h22, 20, 20, 20),     1, "rst_write_blocked");
      rst = 1'b0;
      issue(rtype(6'h2A, 20, 19, 0),      1, "post_rst_r20_ge_19");
      issue(rtype(6'h2A, 19, 20, 0),      0, "post_rst_r20_gt_19");
      issue(32'h01E9A022,                 0, "first_write_after_rst");
      issue(rtype(6'h22, 20, 6, 0),       1, "chk_first_write");

      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            model_reset();
            issue(rand_instr(), -1, "rand_in_reset");
            rst = 1'b0;
         end else begin
            issue(rand_instr(), -1, "rand");
         end
      end

      vld = 1'b0;
      @(negedge clk);
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_tipo_r.md
Name: datapath_tipo_r

Overview:
- Single-cycle MIPS-style R-type datapath: 32x32 register file, ALU control decoder and 32-bit ALU.
- Each clocked instruction reads rs/rt, computes per funct, and writes the result to rd on the rising clock edge.
- The ALU zero flag is exported as ZF_DPTR for branch/compare logic upstream.

Parameters:
- WIDTH, 32, data/register width.
- NREGS, 32, number of registers (address width 5).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- instruccion  input  32  R-type instruction word, held stable across the sampling edge.
- ZF_DPTR  output  1  ALU zero flag, combinational: 1 when the current ALU result == 0.

Behaviour:
- Decode fields:
  - opcode = instruccion[31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
  - shamt = [10:6] (ignored)
  - funct = [5:0]
- Register file: two asynchronous read ports (rs, rt), one synchronous write port (rd).
  - Register 0 always reads 0; writes to it are discarded.
- ALU operation, valid only when opcode == 0, selected by funct:
  - 0x20 add: A + B, wrap modulo 2^32, no overflow trap.
  - 0x22 sub: A - B, wrap modulo 2^32.
  - 0x24 and: A & B.
  - 0x25 or: A | B.
  - 0x2A slt: 1 if signed A < signed B, else 0.
- Any other funct (including 0x00, the all-zero NOP), or opcode != 0:
  - ALU result forced to 0, so ZF_DPTR = 1.
  - RegWrite deasserted.
- RegWrite = (opcode == 0) and funct is supported and rd != 0.
- Write timing: on rising clk with RegWrite = 1, reg[rd] <= ALU result. The new value is visible on read ports after that edge. Zero-cycle latency for the combinational result/flag; writeback latency is one edge.
- Read-during-write: reads return the old value until the edge (no bypass; the datapath has no combinational loop).
- Reset:
  - While rst = 1 (asynchronous assert), reg[i] <= i for i = 0..31, so reg0 = 0, reg5 = 5, reg9 = 9, and so on.
  - Writes are blocked while rst is high.
  - Deassertion is sampled synchronously; the first write occurs on the first rising edge with rst low.
  - Reset asserted mid-sequence discards all prior writes and restores the initial values.
- ZF_DPTR has no reset value of its own; after reset it reflects the ALU result computed from the reset register contents and the current instruction.
- rs == rt == rd is legal (e.g. sub r5,r5,r5 gives 0 with ZF = 1 and writes 0).

Optional Feature:
- Macro: DPTR_DBG_PORT_EN.
- When defined, two extra ports exist:
  - dbg_addr input 5: debug read address.
  - dbg_data output 32: asynchronous third read port, returning reg[dbg_addr] (0 for address 0).
- When undefined, these ports are absent and the register file has two read ports only.
- Core behaviour is identical in both builds.

Test Plan:
- Reset, then sub r20,r15,r9 (0x01E9A022), clock one edge -> ZF_DPTR = 0 before the edge; reg20 = 6 after it.
- NOP 0x00000000 for one edge -> ZF_DPTR = 1, no register changes. Then sub r20,r20,r9 (0x0289A022) -> reg20 = 0xFFFFFFFD, ZF_DPTR = 0.
- add r15,r5,r15 (0x00AF7820), one edge -> reg15 = 20. Then add r15,r9,r15 (0x012F7820) -> reg15 = 29.
- slt r21,r20,r15 (0x028FA82A) after the above -> signed -3 < 29, reg21 = 1, ZF_DPTR = 0. Swap operands (slt r21,r15,r20) -> reg21 = 0, ZF_DPTR = 1.
- Zero/boundary:
  - sub r5,r5,r5 -> ZF_DPTR = 1, reg5 = 0.
  - add r0,r31,r31 -> reg0 stays 0.
  - and/or on reg3 (3) and reg5 (5) -> 1 and 7 respectively.
- Asynchronous reset asserted between edges after writes -> reg20 returns to 20 immediately without a clock edge (checked via the debug port, or by issuing sub r1,r20,r20 and seeing ZF_DPTR = 1 together with the correct reads).
